// File: rtl/btn_conditioner.sv
// Purpose : turns raw push-button pads into a debounced level plus 1-cycle press/release/long/repeat strobes.
// Latency : pad -> level/press_p/release_p = 2 + DEBOUNCE_CYCLES cycles; long_p LONG_CYCLES after press_p.
// Backpr. : none; strobes are fire-and-forget, so the consumer must sample them every cycle.
//
// Ports:
//   clk        100 MHz system clock
//   rst        asynchronous reset, active-low (0 = reset), release synchronous to clk
//   btn_raw    raw asynchronous pad levels, one bit per button
//   level      debounced pressed state (1 = pressed)
//   press_p    1-cycle strobe in the first cycle level reads 1
//   release_p  1-cycle strobe in the first cycle level reads 0
//   long_p     1-cycle strobe once the press has been held LONG_CYCLES cycles
//   repeat_p   1-cycle strobe every REPEAT_CYCLES cycles after long_p while held (0 disables)

module btn_conditioner #(
  parameter int N_BTN           = 2,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press_p,
  output logic [N_BTN-1:0] release_p,
  output logic [N_BTN-1:0] long_p,
  output logic [N_BTN-1:0] repeat_p
);

  localparam int DCNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HCNT_W   = $clog2(HOLD_MAX + 1);

  // Terminal counts: reaching these values on the current cycle means the
  // event fires on the next clock edge.
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] LONG_LAST = HCNT_W'(LONG_CYCLES - 1);
  localparam bit                REPEAT_EN = (REPEAT_CYCLES != 0);
  localparam logic [HCNT_W-1:0] REP_LAST  = REPEAT_EN ? HCNT_W'(REPEAT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LONG = 2'd2
  } hold_state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer on the raw pad level. Reset loads the idle pad level
  // so a released button reads "not pressed" straight out of reset.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= {N_BTN{ACTIVE_LOW}};
      r_sync2 <= {N_BTN{ACTIVE_LOW}};
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Normalize so that 1 always means "pressed" from here on.
  assign w_s = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // ---------------------------------------------------------------------------
  // Per-channel debounce, edge strobes and hold/repeat FSM. Channels share
  // nothing but the clock and reset.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch

    logic [DCNT_W-1:0] r_dcnt;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              w_accept;
    logic              w_press_acc;
    logic              w_rel_acc;

    // A new level is accepted on the edge where the mismatch has already been
    // seen DEBOUNCE_CYCLES-1 times and is still present.
    assign w_accept    = (w_s[g] != r_level) && (r_dcnt == DCNT_LAST);
    assign w_press_acc = w_accept &&  w_s[g];
    assign w_rel_acc   = w_accept && !w_s[g];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_dcnt    <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        // Strobes are registered alongside level so they coincide with the
        // first cycle the new level is visible.
        r_press   <= w_press_acc;
        r_release <= w_rel_acc;
        if (w_s[g] == r_level) begin
          // Any glitch back to the accepted level restarts the count.
          r_dcnt <= '0;
        end else if (w_accept) begin
          r_level <= w_s[g];
          r_dcnt  <= '0;
        end else begin
          r_dcnt  <= r_dcnt + 1'b1;
        end
      end
    end

    // ------------------------- hold / repeat FSM ------------------------------
    hold_state_t       r_state;
    hold_state_t       w_state_nxt;
    logic [HCNT_W-1:0] r_hcnt;
    logic [HCNT_W-1:0] w_hcnt_nxt;
    logic              r_long;
    logic              r_repeat;
    logic              w_long_nxt;
    logic              w_repeat_nxt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state  <= ST_IDLE;
        r_hcnt   <= '0;
        r_long   <= 1'b0;
        r_repeat <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_hcnt   <= w_hcnt_nxt;
        r_long   <= w_long_nxt;
        r_repeat <= w_repeat_nxt;
      end
    end

    always_comb begin
      w_state_nxt  = r_state;
      w_hcnt_nxt   = r_hcnt;
      w_long_nxt   = 1'b0;
      w_repeat_nxt = 1'b0;
      case (r_state)
        ST_IDLE: begin
          w_hcnt_nxt = '0;
          if (w_press_acc) begin
            w_state_nxt = ST_HOLD;
          end
        end

        ST_HOLD: begin
          // A release accepted on this edge takes priority over a long_p that
          // would fire on the same edge, so the two never coincide.
          if (w_rel_acc || !r_level) begin
            w_state_nxt = ST_IDLE;
            w_hcnt_nxt  = '0;
          end else if (r_hcnt == LONG_LAST) begin
            w_long_nxt  = 1'b1;
            w_hcnt_nxt  = '0;
            w_state_nxt = ST_LONG;
          end else begin
            w_hcnt_nxt  = r_hcnt + 1'b1;
          end
        end

        ST_LONG: begin
          if (w_rel_acc || !r_level) begin
            w_state_nxt = ST_IDLE;
            w_hcnt_nxt  = '0;
          end else if (!REPEAT_EN) begin
            w_hcnt_nxt  = '0;
          end else if (r_hcnt == REP_LAST) begin
            w_repeat_nxt = 1'b1;
            w_hcnt_nxt   = '0;
          end else begin
            w_hcnt_nxt   = r_hcnt + 1'b1;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_hcnt_nxt  = '0;
        end
      endcase
    end

    assign level[g]     = r_level;
    assign press_p[g]   = r_press;
    assign release_p[g] = r_release;
    assign long_p[g]    = r_long;
    assign repeat_p[g]  = r_repeat;

    // Structural invariants of the strobe outputs.
    a_press_release_excl : assert property (@(posedge clk) disable iff (!rst)
      !(r_press && r_release));
    a_release_wins : assert property (@(posedge clk) disable iff (!rst)
      r_release |-> !(r_long || r_repeat));
    a_press_has_level : assert property (@(posedge clk) disable iff (!rst)
      r_press |-> r_level);

  end : g_ch

endmodule

// File: tb/tb_btn_conditioner.sv
// Purpose : scoreboard bench for btn_conditioner with small debounce/long/repeat counts.
// Latency : expectations are absolute cycle numbers (cycle k = after the k-th rising edge).
// Backpr. : none; the monitor pops one expected event per cycle in which any strobe is high.

module tb_btn_conditioner;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int LG = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] level;
  logic [NB-1:0] press_p;
  logic [NB-1:0] release_p;
  logic [NB-1:0] long_p;
  logic [NB-1:0] repeat_p;

  btn_conditioner #(
    .N_BTN          (NB),
    .ACTIVE_LOW     (1'b1),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .level    (level),
    .press_p  (press_p),
    .release_p(release_p),
    .long_p   (long_p),
    .repeat_p (repeat_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
    logic [1:0] rp;
    logic [1:0] lv;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_lvl  = 2'b00;

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input logic [1:0] pr, input logic [1:0] rl,
                      input logic [1:0] lg, input logic [1:0] rp, input logic [1:0] lv);
    ev_t e;
    e.c = c; e.pr = pr; e.rl = rl; e.lg = lg; e.rp = rp; e.lv = lv;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after rising edge c, i.e. during cycle c.
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk2("reset_outputs", level | press_p | release_p | long_p | repeat_p, 2'b00);
        exp_lvl = 2'b00;
      end else if ((press_p | release_p | long_p | repeat_p) != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe at cycle %0d: press=%b release=%b long=%b repeat=%b, expected none",
                   cyc, press_p, release_p, long_p, repeat_p);
        end else begin
          e = exp_q.pop_front();
          chki("event_cycle", cyc, e.c);
          chk2("press_p", press_p, e.pr);
          chk2("release_p", release_p, e.rl);
          chk2("long_p", long_p, e.lg);
          chk2("repeat_p", repeat_p, e.rp);
          chk2("level_at_event", level, e.lv);
          exp_lvl = e.lv;
        end
      end else begin
        chk2("level_hold", level, exp_lvl);
      end
    end
  end

  initial begin : stimulus
    ev_t e;
    rst     = 1'b0;
    btn_raw = 2'b00;

    // 1. Reset with both buttons held; release at cycle 3 -> press at 9.
    //    Release both at 13 -> release at 19, exactly where long_p would land.
    push(9,  2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
    push(19, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    wait_cyc(3);  rst = 1'b1;
    wait_cyc(13); btn_raw = 2'b11;

    // 2. Clean press of btn0 at 30, release at 50.
    wait_cyc(30);
    push(36, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    push(46, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
    for (int c = 49; c <= 55; c += RP) push(c, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
    push(56, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    btn_raw = 2'b10;
    wait_cyc(50); btn_raw = 2'b11;

    // 3. Bounce on btn0: low 3, high 1, low 3, high -> nothing.
    wait_cyc(70); btn_raw = 2'b10;
    wait_cyc(73); btn_raw = 2'b11;
    wait_cyc(74); btn_raw = 2'b10;
    wait_cyc(77); btn_raw = 2'b11;

    // 4. Hold btn1 for 40 cycles; the release lands where a repeat would.
    wait_cyc(100);
    push(106, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
    push(116, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10);
    for (int c = 119; c <= 143; c += RP) push(c, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10);
    push(146, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    btn_raw = 2'b01;
    wait_cyc(140); btn_raw = 2'b11;

    // 5. btn0 pressed at 160 for 20 cycles while btn1 bounces.
    wait_cyc(160);
    push(166, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    push(176, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
    for (int c = 179; c <= 185; c += RP) push(c, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
    push(186, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    btn_raw = 2'b00;
    wait_cyc(163); btn_raw = 2'b10;
    wait_cyc(164); btn_raw = 2'b00;
    wait_cyc(167); btn_raw = 2'b10;
    wait_cyc(180); btn_raw = 2'b11;

    // 6. btn1 pressed at 200 (press at 206), reset at 211 for 2 cycles while held.
    wait_cyc(200);
    push(206, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
    btn_raw = 2'b01;
    wait_cyc(211); rst = 1'b0;
    wait_cyc(213); rst = 1'b1;
    push(219, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
    push(229, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10);
    for (int c = 232; c <= 241; c += RP) push(c, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10);
    push(242, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    wait_cyc(236); btn_raw = 2'b11;

    wait_cyc(260);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_event: strobe expected at cycle %0d (press=%b release=%b long=%b repeat=%b) never seen",
               e.c, e.pr, e.rl, e.lg, e.rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the raw board push-buttons (B1, B2) into clean single-cycle event strobes.
- Those strobes drive the LED counter stage on the PMOD outputs, e.g. step, clear or run/stop.
- Per button: 2-flop synchronizer, consecutive-sample debounce, press/release edge pulses, long-press pulse and optional auto-repeat.
- Sits directly upstream of the counter, in the chip top level, on the 100 MHz clock.

Parameters:
N_BTN, 2, number of independent button channels.
ACTIVE_LOW, 1, 1 = pad reads 0 when pressed; input is inverted internally so "pressed" = 1.
DEBOUNCE_CYCLES, 1000000, consecutive cycles a changed level must persist before acceptance (10 ms @ 100 MHz); legal range >= 1.
LONG_CYCLES, 100000000, cycles of accepted press before long_p fires (1 s); legal range > 0.
REPEAT_CYCLES, 20000000, auto-repeat period after long_p; 0 disables repeat.

Ports:
clk  input  1  100 MHz system clock.
rst  input  1  asynchronous reset, active-low (0 = reset).
btn_raw  input  N_BTN  raw asynchronous pad levels.
level  output  N_BTN  debounced pressed state (1 = pressed).
press_p  output  N_BTN  1-cycle strobe on accepted press.
release_p  output  N_BTN  1-cycle strobe on accepted release.
long_p  output  N_BTN  1-cycle strobe when press held LONG_CYCLES.
repeat_p  output  N_BTN  1-cycle strobe every REPEAT_CYCLES after long_p while held.

Behaviour:
- Reset (rst=0, async assert, release synchronous to clk):
  - Sync flops load the inactive pad level.
  - All counters 0.
  - All outputs 0, including level.
- Channels are fully independent; no shared state.
- Sync: s = normalized btn_raw after 2 flops; 2 cycles latency.
- Debounce, per channel, counter dcnt of width clog2(DEBOUNCE_CYCLES+1):
  - s == level: dcnt <= 0.
  - s != level and dcnt < DEBOUNCE_CYCLES-1: dcnt <= dcnt+1.
  - s != level and dcnt == DEBOUNCE_CYCLES-1: level <= s, dcnt <= 0.
  - Net effect: a change must be seen on s for DEBOUNCE_CYCLES consecutive cycles. Any glitch back restarts the count.
  - Total latency pad -> level = 2 + DEBOUNCE_CYCLES cycles.
- Edge strobes:
  - press_p is asserted in the same cycle level first reads 1; release_p in the same cycle level first reads 0.
  - Each strobe is exactly 1 cycle.
- Hold logic, per channel, states IDLE, HOLD, LONG:
  - IDLE: hcnt=0. Accepted press -> HOLD.
  - HOLD: hcnt increments each cycle level=1. When hcnt reaches LONG_CYCLES-1: long_p=1 next cycle, hcnt<=0, -> LONG.
  - LONG: if REPEAT_CYCLES != 0, hcnt counts to REPEAT_CYCLES-1, then repeat_p=1 for one cycle and hcnt<=0, repeating. If REPEAT_CYCLES == 0, hcnt holds 0 and no repeat_p.
  - Any state with level=0 (release accepted) -> IDLE, hcnt<=0, pending strobe suppressed.
  - hcnt width is clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1); counters never wrap.
- Timing from press_p:
  - long_p fires LONG_CYCLES cycles after press_p.
  - The first repeat_p fires REPEAT_CYCLES cycles after long_p.
- Simultaneous events:
  - release_p and long_p/repeat_p never assert in the same cycle; release wins.
  - press_p and release_p are mutually exclusive per channel.
- Reset mid-operation: all state cleared immediately. After release, a still-held button needs a full debounce and produces a fresh press_p.
- Bounce shorter than DEBOUNCE_CYCLES produces no output change.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=1, N_BTN=2):
1. Reset: rst=0 with btn_raw=2'b00 (both pressed) -> all outputs 0 during reset. After rst=1: level[1:0]=11 at cycle 6, press_p=11 for that one cycle.
2. Clean press: btn_raw[0] 1->0 at cycle T -> level[0]=1 and press_p[0]=1 at T+6. Release at T+20 -> level[0]=0 and release_p[0]=1 at T+26.
3. Bounce: btn_raw[0] low for 3 cycles, high 1, low 3, then back high -> level[0] stays 0, no strobes.
4. Long/repeat: hold btn[1] 40 cycles -> press_p at P, long_p at P+10, repeat_p at P+13, P+16, P+19 ... Release -> release_p, no further repeat_p.
5. Independence: btn0 pressed while btn1 bounces -> btn0 strobes exact per scenario 2; btn1 outputs 0.
6. Reset mid-hold: rst=0 at P+5 for 2 cycles, button still held -> outputs 0. New press_p 6 cycles after rst=1; long_p 10 cycles after that.
